// File: rtl/ipu_poll_ctrl_if.sv
// rtl/ipu_poll_ctrl_if.sv - shared-bus master bundle between ipu_poll_ctrl and the IPU fabric
interface ipu_poll_ctrl_if;
    logic        bus_req_o;
    logic        bus_gnt_i;
    logic        m_read_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_i;
    logic        m_ack_i;

    modport master (
        output bus_req_o, m_read_o, m_addr_o,
        input  bus_gnt_i, m_data_i, m_ack_i
    );

    modport slave (
        input  bus_req_o, m_read_o, m_addr_o,
        output bus_gnt_i, m_data_i, m_ack_i
    );
endinterface

// File: rtl/ipu_poll_ctrl.sv
// rtl/ipu_poll_ctrl.sv - periodic IPU cursor poller with CTRL/STATUS slave registers
// Optional coordinate smoothing is built when IPU_POLL_SMOOTH_EN is defined.
module ipu_poll_ctrl #(
    parameter logic [31:0] POLL_ADDR = 32'h40000200,
    parameter logic [31:0] CTRL_ADDR = 32'h40000210,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    ipu_poll_ctrl_if.master m_bus,
    input  logic            write_i,
    input  logic            read_i,
    input  logic [31:0]     addr_i,
    input  logic [31:0]     data_i,
    inout  wire  [31:0]     data_o,
    inout  wire             ack_o,
    output logic            cursor_valid_o,
    output logic [9:0]      cursor_row_o,
    output logic [9:0]      cursor_col_o
);
    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_READ, S_UPDATE} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [15:0] r_cnt, r_tmo_cnt, r_period;
    logic        r_en, r_tmo, r_fresh, r_cv;
    logic [9:0]  r_row, r_col;
    logic [21:0] r_data;
    logic        w_load, w_set_tmo, w_capture;
    logic        w_sel, w_ctrl_wr, w_stat_rd, w_upd_valid;
    logic [9:0]  w_raw_row, w_raw_col, w_row_nxt, w_col_nxt;
    logic [31:0] w_rd_data;
    logic        w_unused_bits;

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_set_tmo = 1'b0;
        w_capture = 1'b0;
        unique case (r_state)
            S_IDLE: if (r_en) begin
                w_next = S_WAIT;
                w_load = 1'b1;
            end
            S_WAIT: begin
                if (!r_en)             w_next = S_IDLE;
                else if (r_cnt == '0)  w_next = S_REQ;
            end
            S_REQ: begin
                if (!r_en)                 w_next = S_IDLE;
                else if (m_bus.bus_gnt_i)  w_next = S_READ;
            end
            // An access in flight is never abandoned by en; only ack or timeout ends it.
            S_READ: begin
                if (m_bus.m_ack_i) begin
                    w_next    = S_UPDATE;
                    w_capture = 1'b1;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_set_tmo = 1'b1;
                    w_next    = r_en ? S_WAIT : S_IDLE;
                    w_load    = r_en;
                end
            end
            S_UPDATE: begin
                w_next = r_en ? S_WAIT : S_IDLE;
                w_load = r_en;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_tmo_cnt <= '0;
            r_data    <= '0;
        end else begin
            r_state   <= w_next;
            if (w_load)
                r_cnt <= r_period;
            else if (r_state == S_WAIT && r_cnt != '0)
                r_cnt <= r_cnt - 16'd1;
            r_tmo_cnt <= (r_state == S_READ) ? r_tmo_cnt + 16'd1 : 16'd0;
            if (w_capture)
                r_data <= m_bus.m_data_i[21:0];
        end
    end

    assign m_bus.bus_req_o = (r_state == S_REQ) || (r_state == S_READ);
    assign m_bus.m_read_o  = (r_state == S_READ);
    assign m_bus.m_addr_o  = (r_state == S_READ) ? POLL_ADDR : 32'd0;

    assign w_raw_col   = r_data[11:2];
    assign w_raw_row   = r_data[21:12];
    assign w_upd_valid = (r_state == S_UPDATE) && r_data[0];

`ifdef IPU_POLL_SMOOTH_EN
    logic [10:0] w_sum_row, w_sum_col;
    assign w_sum_row = {1'b0, r_row} + {1'b0, w_raw_row};
    assign w_sum_col = {1'b0, r_col} + {1'b0, w_raw_col};
    // A fresh track (cursor absent before) starts from the raw sample, not a blend with stale data.
    assign w_row_nxt = r_cv ? w_sum_row[10:1] : w_raw_row;
    assign w_col_nxt = r_cv ? w_sum_col[10:1] : w_raw_col;
`else
    assign w_row_nxt = w_raw_row;
    assign w_col_nxt = w_raw_col;
`endif

    assign w_sel     = (addr_i[31:3] == CTRL_ADDR[31:3]) && (read_i || write_i);
    assign w_ctrl_wr = w_sel && write_i && !addr_i[2];
    assign w_stat_rd = w_sel && read_i && addr_i[2];
    assign w_rd_data = addr_i[2] ? {9'd0, r_row, r_col, r_cv, r_fresh, r_tmo}
                                 : {r_period, 15'd0, r_en};
    assign data_o    = w_sel ? w_rd_data : 32'bz;
    assign ack_o     = w_sel ? 1'b1 : 1'bz;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en     <= 1'b0;
            r_period <= '0;
            r_tmo    <= 1'b0;
            r_fresh  <= 1'b0;
            r_cv     <= 1'b0;
            r_row    <= '0;
            r_col    <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_en     <= data_i[0];
                r_period <= data_i[31:16];
            end
            // Set has priority over the read-to-clear of the same cycle.
            if (w_set_tmo)      r_tmo <= 1'b1;
            else if (w_stat_rd) r_tmo <= 1'b0;
            if (w_upd_valid)    r_fresh <= 1'b1;
            else if (w_stat_rd) r_fresh <= 1'b0;
            if (w_upd_valid) begin
                r_cv <= r_data[1];
                if (r_data[1]) begin
                    r_row <= w_row_nxt;
                    r_col <= w_col_nxt;
                end
            end
        end
    end

    assign cursor_valid_o = r_cv;
    assign cursor_row_o   = r_row;
    assign cursor_col_o   = r_col;

    assign w_unused_bits = ^{m_bus.m_data_i[31:22], data_i[15:1], addr_i[1:0]};
endmodule

// File: tb/tb_ipu_poll_ctrl.sv
// tb/tb_ipu_poll_ctrl.sv - self-checking bench for ipu_poll_ctrl with a behavioural poll model
`timescale 1ns/1ps
module tb_ipu_poll_ctrl;
    localparam logic [31:0] POLL_ADDR = 32'h40000200;
    localparam logic [31:0] CTRL_ADDR = 32'h40000210;
    localparam int          TIMEOUT   = 16;
`ifdef IPU_POLL_SMOOTH_EN
    localparam logic [9:0]  COL_SECOND = 10'd150;
`else
    localparam logic [9:0]  COL_SECOND = 10'd200;
`endif

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b1;
    logic        write_i = 1'b0, read_i = 1'b0;
    logic [31:0] addr_i  = '0, data_i = '0;
    wire  [31:0] s_data;
    wire         s_ack;
    logic        cursor_valid_o;
    logic [9:0]  cursor_row_o, cursor_col_o;

    logic        gnt = 1'b0, ack_on = 1'b0;
    logic [31:0] rdata = '0;
    int          ack_dly = 0, rd_age = 0, cyc = 0;
    int          n_cmp = 0, n_fail = 0;

    ipu_poll_ctrl_if bus();
    assign bus.bus_gnt_i = gnt;
    assign bus.m_data_i  = rdata;
    assign bus.m_ack_i   = bus.m_read_o && ack_on && (rd_age >= ack_dly);

    ipu_poll_ctrl #(.POLL_ADDR(POLL_ADDR), .CTRL_ADDR(CTRL_ADDR), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .m_bus(bus),
        .write_i(write_i), .read_i(read_i), .addr_i(addr_i), .data_i(data_i),
        .data_o(s_data), .ack_o(s_ack),
        .cursor_valid_o(cursor_valid_o), .cursor_row_o(cursor_row_o), .cursor_col_o(cursor_col_o)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) begin
        rd_age <= bus.m_read_o ? rd_age + 1 : 0;
        cyc    <= cyc + 1;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Behavioural model: register image, cursor, and observed bus-phase bookkeeping
    logic        m_en = 0, m_tmo = 0, m_fresh = 0, m_cv = 0;
    logic [15:0] m_period = 0;
    logic [9:0]  m_row = 0, m_col = 0;
    int          pend_cnt = 0, run = 0, gap = 0, gap_exp = 0, wr_age = 0;
    logic [21:0] pend_data = 0;
    logic        p_ctrl_wr = 0, p_stat_rd = 0, gap_ok = 0;
    logic [31:0] p_ctrl_data = 0;
    logic        pv_req = 0, pv_read = 0, pv_ack = 0, pv_gnt = 0, pv_en = 0;

    function automatic logic [31:0] status_word();
        return {9'd0, m_row, m_col, m_cv, m_fresh, m_tmo};
    endfunction

    function automatic void apply_sample(input logic [21:0] d);
        int nr, nc;
        if (d[0]) begin
            m_fresh = 1'b1;
            if (d[1]) begin
                nr = int'(d[21:12]);
                nc = int'(d[11:2]);
`ifdef IPU_POLL_SMOOTH_EN
                if (m_cv) begin
                    nr = (int'(m_row) + nr) / 2;
                    nc = (int'(m_col) + nc) / 2;
                end
`endif
                m_row = 10'(nr);
                m_col = 10'(nc);
                m_cv  = 1'b1;
            end else begin
                m_cv = 1'b0;
            end
        end
    endfunction

    always @(negedge sys_clk) begin
        if (!rst_n) begin
            m_en = 0; m_period = 0; m_tmo = 0; m_fresh = 0; m_cv = 0; m_row = 0; m_col = 0;
            pend_cnt = 0; run = 0; gap_ok = 0; wr_age = 0; p_ctrl_wr = 0; p_stat_rd = 0;
            pv_req = 0; pv_read = 0; pv_ack = 0; pv_gnt = 0; pv_en = 0;
            chk("rst_outputs", {bus.bus_req_o, bus.m_read_o, cursor_valid_o, cursor_row_o, cursor_col_o}, 0);
            chk("rst_m_addr", bus.m_addr_o, 0);
        end else begin
            if (p_ctrl_wr) begin
                m_en     = p_ctrl_data[0];
                m_period = p_ctrl_data[31:16];
            end
            if (p_stat_rd) begin
                m_tmo   = 1'b0;
                m_fresh = 1'b0;
            end
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) apply_sample(pend_data);
            end
            if (pv_read && !pv_ack && !bus.m_read_o) begin
                chk("timeout_len", 32'(run), TIMEOUT);
                m_tmo = 1'b1;
            end
            if (bus.m_read_o) run = pv_read ? run + 1 : 1;
            if (bus.m_read_o && run == TIMEOUT + 1) chk("read_too_long", 32'(run), TIMEOUT);
            if (bus.m_read_o && bus.m_ack_i) begin
                pend_cnt  = 2;
                pend_data = bus.m_data_i[21:0];
            end
            wr_age++;
            if (pv_read && !bus.m_read_o) begin
                gap     = 1;
                gap_exp = int'(m_period) + (pv_ack ? 3 : 2);
                gap_ok  = (wr_age >= 3) && m_en;
            end else if (!bus.m_read_o) begin
                gap++;
            end
            if (bus.bus_req_o && !pv_req && gap_ok) begin
                chk("poll_gap", 32'(gap), 32'(gap_exp));
                gap_ok = 1'b0;
            end

            chk("cursor_valid", cursor_valid_o, m_cv);
            chk("cursor_row", cursor_row_o, m_row);
            chk("cursor_col", cursor_col_o, m_col);
            chk("m_addr", bus.m_addr_o, bus.m_read_o ? POLL_ADDR : 32'd0);
            if (bus.m_read_o) chk("req_during_read", bus.bus_req_o, 1);
            if (bus.m_read_o && !pv_read) chk("read_needs_grant", {pv_req, pv_gnt}, 2'b11);
            if (pv_req && !pv_read && pv_gnt && pv_en) chk("grant_to_read", bus.m_read_o, 1);
            if (!pv_en && !pv_read) chk("idle_when_off", {bus.bus_req_o, bus.m_read_o}, 0);

            p_ctrl_wr = 1'b0;
            p_stat_rd = 1'b0;
            if ((read_i || write_i) && addr_i[31:3] == CTRL_ADDR[31:3]) begin
                chk("slave_ack", s_ack, 1);
                if (read_i)
                    chk(addr_i[2] ? "status_rd" : "ctrl_rd", s_data,
                        addr_i[2] ? status_word() : {m_period, 15'd0, m_en});
                if (write_i && !addr_i[2]) begin
                    p_ctrl_wr   = 1'b1;
                    p_ctrl_data = data_i;
                    gap_ok      = 1'b0;
                    wr_age      = 0;
                end
                if (read_i && addr_i[2]) p_stat_rd = 1'b1;
            end
            pv_req = bus.bus_req_o; pv_read = bus.m_read_o; pv_ack = bus.m_ack_i;
            pv_gnt = gnt; pv_en = m_en;
        end
    end

    task automatic sync();
        @(posedge sys_clk); #1;
    endtask

    task automatic ctrl_write(input logic en, input logic [15:0] per);
        write_i = 1'b1; addr_i = CTRL_ADDR; data_i = {per, 15'h2AAA, en};
        sync();
        write_i = 1'b0;
    endtask

    task automatic slave_read(input logic [31:0] a, output logic [31:0] v);
        read_i = 1'b1; addr_i = a;
        @(negedge sys_clk);
        v = s_data;
        sync();
        read_i = 1'b0;
    endtask

    task automatic wait_rise(input string nm);
        int k = 0;
        @(negedge sys_clk);
        while (bus.m_read_o && k < 100) begin @(negedge sys_clk); k++; end
        while (!bus.m_read_o && k < 300) begin @(negedge sys_clk); k++; end
        chk({nm, "_rise"}, bus.m_read_o, 1);
    endtask

    logic [31:0] v;
    int          t0, n, bad, r;

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {bus.bus_req_o, bus.m_read_o, cursor_valid_o}, 0);
        repeat (3) @(negedge sys_clk);
        #2 rst_n = 1'b1;
        sync();
        slave_read(CTRL_ADDR + 4, v); chk("reset_status", v, 0);
        slave_read(CTRL_ADDR, v);     chk("reset_ctrl", v, 0);

        gnt = 1'b1; ack_on = 1'b1; ack_dly = 0; rdata = 32'h00064083;
        ctrl_write(1'b1, 16'd3);
        slave_read(CTRL_ADDR, v);     chk("ctrl_readback", v, {16'd3, 15'd0, 1'b1});
        wait_rise("p1");
        t0 = cyc;
        wait_rise("p2");
        chk("poll_interval", 32'(cyc - t0), 7);
        @(negedge sys_clk); @(negedge sys_clk);
        chk("lit_cursor", {cursor_valid_o, cursor_row_o, cursor_col_o}, {1'b1, 10'd100, 10'd32});
        sync();
        slave_read(CTRL_ADDR + 4, v);
        chk("lit_status", v[22:1], {10'd100, 10'd32, 1'b1, 1'b1});

        gnt = 1'b0;
        n = 0;
        while (!(bus.bus_req_o && !bus.m_read_o) && n < 50) begin @(negedge sys_clk); n++; end
        bad = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (!bus.bus_req_o || bus.m_read_o) bad++;
        end
        chk("req_hold_no_grant", 32'(bad), 0);
        sync();
        gnt = 1'b1;
        @(negedge sys_clk); chk("no_read_same_cycle", bus.m_read_o, 0);
        @(negedge sys_clk); chk("read_after_grant", bus.m_read_o, 1);

        sync();
        ack_on = 1'b0;
        wait_rise("tmo");
        n = 1;
        while (bus.m_read_o && n < 40) begin
            @(negedge sys_clk);
            if (bus.m_read_o) n++;
        end
        chk("lit_tmo_len", 32'(n), 16);
        sync();
        slave_read(CTRL_ADDR + 4, v); chk("tmo_set", v[0], 1);
        slave_read(CTRL_ADDR + 4, v); chk("tmo_cleared", v[0], 0);

        ack_on = 1'b1; rdata = 32'h00123456;
        slave_read(CTRL_ADDR + 4, v);
        wait_rise("inv");
        @(negedge sys_clk); @(negedge sys_clk);
        chk("invalid_keeps_cursor", {cursor_valid_o, cursor_row_o, cursor_col_o}, {1'b1, 10'd100, 10'd32});
        sync();
        slave_read(CTRL_ADDR + 4, v); chk("invalid_no_fresh", v[1], 0);
        rdata = 32'h00355551;
        wait_rise("absent");
        @(negedge sys_clk); @(negedge sys_clk);
        chk("absent_holds_pos", {cursor_valid_o, cursor_row_o, cursor_col_o}, {1'b0, 10'd100, 10'd32});
        sync();
        slave_read(CTRL_ADDR + 4, v); chk("absent_fresh", v[2:1], 2'b01);

        rdata = (32'd100 << 2) | 32'd3;
        wait_rise("s1");
        @(negedge sys_clk); @(negedge sys_clk);
        chk("smooth_first", {cursor_valid_o, cursor_row_o, cursor_col_o}, {1'b1, 10'd0, 10'd100});
        sync();
        rdata = (32'd200 << 2) | 32'd3;
        wait_rise("s2");
        @(negedge sys_clk); @(negedge sys_clk);
        chk("smooth_second", cursor_col_o, COL_SECOND);

        sync();
        ctrl_write(1'b0, 16'd3);
        bad = 0;
        repeat (20) begin
            @(negedge sys_clk);
            if (bus.bus_req_o) bad++;
        end
        chk("disabled_no_req", 32'(bad), 0);

        sync();
        ack_on = 1'b0;
        ctrl_write(1'b1, 16'd0);
        wait_rise("pre_rst");
        @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_read", {bus.bus_req_o, bus.m_read_o, cursor_valid_o, cursor_row_o, cursor_col_o}, 0);
        chk("rst_mid_read_addr", bus.m_addr_o, 0);
        @(negedge sys_clk);
        #2 rst_n = 1'b1;
        sync();
        slave_read(CTRL_ADDR, v); chk("ctrl_after_rst", v, 0);

        ack_on = 1'b1;
        ctrl_write(1'b1, 16'd2);
        for (int i = 0; i < 3000; i++) begin
            gnt   = ($urandom_range(0, 3) != 0);
            rdata = $urandom;
            if ($urandom_range(0, 19) == 0) begin
                ack_on  = ($urandom_range(0, 7) != 0);
                ack_dly = $urandom_range(0, 3);
            end
            write_i = 1'b0; read_i = 1'b0;
            r = $urandom_range(0, 99);
            if (r < 8) begin
                read_i = 1'b1; addr_i = CTRL_ADDR + 4;
            end else if (r < 10) begin
                read_i = 1'b1; addr_i = CTRL_ADDR;
            end else if (r < 12) begin
                write_i = 1'b1;
                addr_i  = CTRL_ADDR + 32'($urandom_range(0, 1) * 4);
                data_i  = {16'($urandom_range(0, 5)), 15'($urandom), 1'($urandom_range(0, 5) != 0)};
            end else if (r < 14) begin
                read_i = 1'b1; addr_i = 32'h40000300;
            end
            sync();
        end
        write_i = 1'b0; read_i = 1'b0;
        repeat (5) sync();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_fail);
        $fatal(1);
    end
endmodule
